// File: rtl/phase_sched_pkg.sv
// Shared types and sizing helpers for the phase frame scheduler and its phase bank.
package phase_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      ARMED  = 2'd2,
      COMMIT = 2'd3
   } state_t;

   localparam int FRAME_CNT_W = 16;

   // Channel index width; a single channel still needs one index bit.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/phase_bank.sv
// Shadow/active phase storage with a written-channel mask and single-cycle
// copy of the whole shadow bank into the active bank on commit.
module phase_bank
   import phase_sched_pkg::*;
#(
   parameter int NUM_CHANNELS = 128,
   parameter int CLK_CNT_W    = 8,
   localparam int CH_W        = ch_w(NUM_CHANNELS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [CH_W-1:0]         wr_channel,
   input  logic [CLK_CNT_W-1:0]    wr_phase,
   input  logic                    commit,
   output logic [CLK_CNT_W-1:0]    active [NUM_CHANNELS],
   output logic [NUM_CHANNELS-1:0] mask
);

   logic [CLK_CNT_W-1:0] shadow [NUM_CHANNELS];

   // Shadow is never cleared on commit so unwritten channels carry forward.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         mask <= '0;
      end else begin
         if (wr_en) begin
            shadow[wr_channel] <= wr_phase;
            mask[wr_channel]   <= 1'b1;
         end
         if (commit) begin
            active <= shadow;
            mask   <= '0;
         end
      end
   end

endmodule

// File: rtl/phase_frame_scheduler.sv
// Collects per-channel phase writes into a shadow bank and commits a whole
// frame to the PWM array only at a PWM period boundary.
// Optional frame watchdog (mute after idle periods) is built when FRAME_WATCHDOG_EN is defined.
module phase_frame_scheduler
   import phase_sched_pkg::*;
#(
   parameter int NUM_CHANNELS = 128,
   parameter int CLK_CNT_W    = 8,
   parameter int CLK_CNT_MAX  = 249,
`ifdef FRAME_WATCHDOG_EN
   parameter int WDOG_PERIODS = 40000,
   parameter int WDOG_W       = 16,
`endif
   localparam int CH_W        = ch_w(NUM_CHANNELS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CLK_CNT_W-1:0]    cnt,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [CH_W-1:0]         wr_channel,
   input  logic [CLK_CNT_W-1:0]    wr_phase,
   input  logic                    wr_last,
   input  logic                    err_clr,
   output logic [CLK_CNT_W-1:0]    phases [NUM_CHANNELS],
   output logic [NUM_CHANNELS-1:0] pwm_en,
   output logic                    commit_pulse,
   output logic                    frame_pending,
   output logic [FRAME_CNT_W-1:0]  frame_cnt,
   output logic                    err_chan,
   output logic                    mute
);

   state_t state;
   state_t state_nxt;

   logic                    boundary;
   logic                    chan_bad;
   logic                    accept;
   logic                    commit_go;
   logic [NUM_CHANNELS-1:0] mask;
   logic [NUM_CHANNELS-1:0] pwm_en_r;
   logic [FRAME_CNT_W-1:0]  frame_cnt_r;
   logic                    err_chan_r;
   logic                    mute_s;

   assign boundary = (cnt == CLK_CNT_W'(CLK_CNT_MAX));
   assign chan_bad = ({1'b0, wr_channel} >= (CH_W + 1)'(NUM_CHANNELS));
   assign accept   = wr_valid && wr_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded handshake/status outputs.
   always_comb begin
      state_nxt     = state;
      wr_ready      = 1'b0;
      frame_pending = 1'b0;
      commit_pulse  = 1'b0;
      commit_go     = 1'b0;
      case (state)
         IDLE, LOAD: begin
            wr_ready = !rst;
            if (wr_valid && !rst) begin
               state_nxt = wr_last ? ARMED : LOAD;
            end else begin
               state_nxt = state;
            end
         end
         ARMED: begin
            frame_pending = 1'b1;
            // The wr_last cycle is spent in IDLE/LOAD, so it can never be taken as a boundary here.
            if (boundary) begin
               state_nxt = COMMIT;
               commit_go = 1'b1;
            end else begin
               state_nxt = ARMED;
            end
         end
         COMMIT: begin
            commit_pulse = 1'b1;
            state_nxt    = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   phase_bank #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .CLK_CNT_W    (CLK_CNT_W)
   ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (accept && !chan_bad),
      .wr_channel (wr_channel),
      .wr_phase   (wr_phase),
      .commit     (commit_go),
      .active     (phases),
      .mask       (mask)
   );

   // Frame counter, cumulative channel enables and sticky channel error.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_r <= '0;
         pwm_en_r    <= '0;
         err_chan_r  <= 1'b0;
      end else begin
         if (commit_go) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
            pwm_en_r    <= pwm_en_r | mask;
         end
         // A fresh error outranks a simultaneous clear.
         if (accept && chan_bad) begin
            err_chan_r <= 1'b1;
         end else if (err_clr) begin
            err_chan_r <= 1'b0;
         end
      end
   end

`ifdef FRAME_WATCHDOG_EN
   localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_PERIODS);

   logic [WDOG_W-1:0] wdog_cnt;
   logic              mute_r;

   // Boundaries since the last commit; saturates and mutes at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt <= '0;
         mute_r   <= 1'b0;
      end else if (commit_go) begin
         wdog_cnt <= '0;
         mute_r   <= 1'b0;
      end else if (boundary && (wdog_cnt != WDOG_LIMIT)) begin
         wdog_cnt <= wdog_cnt + WDOG_W'(1);
         mute_r   <= (wdog_cnt == (WDOG_LIMIT - WDOG_W'(1)));
      end
   end

   assign mute_s = mute_r;
`else
   assign mute_s = 1'b0;
`endif

   assign mute      = mute_s;
   assign pwm_en    = mute_s ? '0 : pwm_en_r;
   assign frame_cnt = frame_cnt_r;
   assign err_chan  = err_chan_r;

endmodule

// File: tb/tb_phase_frame_scheduler.sv
// Scoreboard bench for phase_frame_scheduler: stimulus pushes expected commits,
// a monitor pops and checks them whenever commit_pulse is seen.
module tb_phase_frame_scheduler;

   localparam int NCH  = 100;
   localparam int CMAX = 249;

   typedef struct packed {
      logic [31:0]         cyc;
      logic [15:0]         fcnt;
      logic [NCH-1:0]      en;
      logic [NCH-1:0][7:0] ph;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] cnt;
   logic       wr_valid;
   logic       wr_ready;
   logic [6:0] wr_channel;
   logic [7:0] wr_phase;
   logic       wr_last;
   logic       err_clr;
   logic [7:0] phases [NCH];
   logic [NCH-1:0] pwm_en;
   logic       commit_pulse;
   logic       frame_pending;
   logic [15:0] frame_cnt;
   logic       err_chan;
   logic       mute;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_commit_cyc = 0;

   exp_t sbq [$];

   logic [NCH-1:0][7:0] m_shadow;
   logic [NCH-1:0][7:0] m_active;
   logic [NCH-1:0]      m_mask;
   logic [NCH-1:0]      m_en;
   logic [15:0]         m_fcnt;

   phase_frame_scheduler #(
      .NUM_CHANNELS (NCH),
      .CLK_CNT_W    (8),
`ifdef FRAME_WATCHDOG_EN
      .WDOG_PERIODS (4),
      .WDOG_W       (16),
`endif
      .CLK_CNT_MAX  (CMAX)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cnt           (cnt),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_channel    (wr_channel),
      .wr_phase      (wr_phase),
      .wr_last       (wr_last),
      .err_clr       (err_clr),
      .phases        (phases),
      .pwm_en        (pwm_en),
      .commit_pulse  (commit_pulse),
      .frame_pending (frame_pending),
      .frame_cnt     (frame_cnt),
      .err_chan      (err_chan),
      .mute          (mute)
   );

   always #5 clk = ~clk;

   // Free-running shared PWM counter and cycle index, advanced mid-cycle.
   initial begin
      cnt = 8'd0;
      forever begin
         @(negedge clk);
         cyc++;
         cnt = (cnt == 8'(CMAX)) ? 8'd0 : cnt + 8'd1;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic int nonzero_phases();
      int n = 0;
      for (int i = 0; i < NCH; i++) if (phases[i] != 8'd0) n++;
      return n;
   endfunction

   // Issue one write, wait (bounded) for acceptance, update the model.
   task automatic wr(input int ch, input int ph, input bit last, input bit clr = 1'b0);
      int   n = 0;
      exp_t e;
      tick();
      wr_valid = 1'b1; wr_channel = 7'(ch); wr_phase = 8'(ph); wr_last = last; err_clr = clr;
      while (wr_ready !== 1'b1 && n < 600) begin
         tick();
         n++;
      end
      check("wr_accept", {127'd0, wr_ready}, 128'd1);
      if (ch < NCH) begin
         m_shadow[ch] = 8'(ph);
         m_mask[ch]   = 1'b1;
      end
      if (last) begin
         m_active       = m_shadow;
         m_en           = m_en | m_mask;
         m_mask         = '0;
         m_fcnt         = m_fcnt + 16'd1;
         exp_commit_cyc = cyc + 2 + (CMAX - ((int'(cnt) + 1) % (CMAX + 1)));
         e.cyc  = 32'(exp_commit_cyc);
         e.fcnt = m_fcnt;
         e.en   = m_en;
         e.ph   = m_active;
         sbq.push_back(e);
      end
   endtask

   // Wait for the pending commit; optionally hammer the write port while armed.
   task automatic wait_commit(input bit junk);
      bit hold_ok = 1'b1;
      int n = 0;
      while (sbq.size() != 0 && n < 600) begin
         tick();
         n++;
         err_clr = 1'b0;
         if (cyc < exp_commit_cyc) begin
            wr_valid = junk; wr_channel = 7'd1; wr_phase = 8'hEE; wr_last = 1'b1;
            if (!(frame_pending === 1'b1 && wr_ready === 1'b0)) hold_ok = 1'b0;
         end else begin
            wr_valid = 1'b0; wr_last = 1'b0;
            if (cyc == exp_commit_cyc && wr_ready !== 1'b0) hold_ok = 1'b0;
         end
      end
      check("armed_hold", {127'd0, hold_ok}, 128'd1);
      check("commit_seen", 128'(sbq.size()), 128'd0);
   endtask

   task automatic wait_cnt(input int v);
      int n = 0;
      while (int'(cnt) != v && n < 300) begin
         tick();
         n++;
      end
   endtask

   // Monitor: every commit_pulse must match the oldest expected frame.
   initial begin : monitor
      exp_t e;
      int   nbad;
      int   first;
      forever begin
         @(negedge clk);
         #2;
         if (commit_pulse === 1'b1) begin
            if (sbq.size() == 0) begin
               check("unexpected_commit", 128'(sbq.size()), 128'd1);
            end else begin
               e = sbq.pop_front();
               check("commit_cycle", 128'(cyc), 128'(e.cyc));
               check("frame_cnt", 128'(frame_cnt), 128'(e.fcnt));
               check("pwm_en", 128'(pwm_en), 128'(e.en));
               check("mute_at_commit", {127'd0, mute}, 128'd0);
               nbad  = 0;
               first = -1;
               for (int i = 0; i < NCH; i++) begin
                  if (phases[i] !== e.ph[i]) begin
                     nbad++;
                     if (first < 0) first = i;
                  end
               end
               if (first >= 0)
                  $display("  first differing channel %0d: got %0h want %0h", first, phases[first], e.ph[first]);
               check("phase_mismatches", 128'(nbad), 128'd0);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; err_clr = 1'b0;
      wr_channel = 7'd0; wr_phase = 8'd0;
      m_shadow = '0; m_active = '0; m_mask = '0; m_en = '0; m_fcnt = 16'd0;

      repeat (3) tick();
      check("reset_wr_ready", {127'd0, wr_ready}, 128'd0);
      tick();
      rst = 1'b0;
      #1;
      check("reset_pending", {127'd0, frame_pending}, 128'd0);
      check("reset_commit", {127'd0, commit_pulse}, 128'd0);
      check("reset_frame_cnt", 128'(frame_cnt), 128'd0);
      check("reset_err", {127'd0, err_chan}, 128'd0);
      check("reset_mute", {127'd0, mute}, 128'd0);
      check("reset_pwm_en", 128'(pwm_en), 128'd0);
      check("reset_phases", 128'(nonzero_phases()), 128'd0);
      check("idle_wr_ready", {127'd0, wr_ready}, 128'd1);

      // Frame 1: ch0=10 then ch5=200 (last) at cnt 100.
      wait_cnt(98);
      wr(0, 10, 1'b0);
      wr(5, 200, 1'b1);
      wait_commit(1'b0);
      check("f1_ph0", 128'(phases[0]), 128'd10);
      check("f1_ph5", 128'(phases[5]), 128'd200);

      // Frame 2: wr_last accepted exactly on the boundary value.
      wait_cnt(248);
      wr(7, 8'h33, 1'b1);
      check("last_at_boundary_cnt", 128'(cnt), 128'd249);
      wait_commit(1'b1);

      // Frames 3/4: last write wins; unwritten channel retained.
      wr(3, 7, 1'b0);
      wr(3, 9, 1'b1);
      wait_commit(1'b0);
      wr(4, 1, 1'b1);
      wait_commit(1'b0);
      check("ch3_retained", 128'(phases[3]), 128'd9);
      check("ch4_new", 128'(phases[4]), 128'd1);

      // Out-of-range channel: accepted, dropped, sticky error.
      wr(110, 8'h55, 1'b1);
      tick();
      wr_valid = 1'b0; wr_last = 1'b0;
      check("err_set", {127'd0, err_chan}, 128'd1);
      wait_commit(1'b0);
      check("err_sticky", {127'd0, err_chan}, 128'd1);
      tick(); err_clr = 1'b1;
      tick(); err_clr = 1'b0;
      check("err_cleared", {127'd0, err_chan}, 128'd0);
      wr(100, 8'h66, 1'b1, 1'b1);
      wr(110, 8'h55, 1'b1);
      tick();
      wr_valid = 1'b0; wr_last = 1'b0; err_clr = 1'b0;
      check("err_set_beats_clr", {127'd0, err_chan}, 128'd1);
      wait_commit(1'b0);

      // Mid-frame reset discards both banks.
      wr(1, 11, 1'b0);
      wr(99, 33, 1'b0);
      wr(120, 1, 1'b0);
      tick();
      wr_valid = 1'b0; rst = 1'b1;
      #1;
      check("rst_wr_ready", {127'd0, wr_ready}, 128'd0);
      tick();
      rst = 1'b0;
      #1;
      m_shadow = '0; m_active = '0; m_mask = '0; m_en = '0; m_fcnt = 16'd0;
      check("rst_frame_cnt", 128'(frame_cnt), 128'd0);
      check("rst_pwm_en", 128'(pwm_en), 128'd0);
      check("rst_phases", 128'(nonzero_phases()), 128'd0);
      check("rst_err", {127'd0, err_chan}, 128'd0);
      check("rst_pending", {127'd0, frame_pending}, 128'd0);
      wr(2, 5, 1'b1);
      wait_commit(1'b0);
      check("post_rst_ch1", 128'(phases[1]), 128'd0);
      check("post_rst_ch99", 128'(phases[99]), 128'd0);

`ifdef FRAME_WATCHDOG_EN
      begin : wdog_test
         int nb = 0;
         int n  = 0;
         while (nb < 4 && n < 1200) begin
            tick();
            n++;
            if (int'(cnt) == CMAX) nb++;
         end
         check("wdog_not_yet", {127'd0, mute}, 128'd0);
         tick();
         check("wdog_mute", {127'd0, mute}, 128'd1);
         check("wdog_pwm_off", 128'(pwm_en), 128'd0);
         check("wdog_bank_kept", 128'(phases[2]), 128'd5);
         wr(6, 66, 1'b1);
         wait_commit(1'b0);
      end
`endif

      check("scoreboard_empty", 128'(sbq.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
